// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the decode stage.
// slave is the decode stage, master drives fetch and consumes execute.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [4:0]        out_rd;
    logic [2:0]        out_func3;
    logic [XLEN-1:0]   out_imm;
    logic [3:0]        out_alu_opt;
    logic [1:0]        out_left_opt;
    logic [1:0]        out_right_opt;
    logic [1:0]        out_pc_jump;
    logic              out_reg_wen;
    logic              out_mem_wen;
    logic              out_load;
    logic [XLEN/8-1:0] out_wmask;
    logic              out_word;
    logic              out_illegal;
    logic              out_ebreak;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
        output out_func3, out_imm, out_alu_opt, out_left_opt,
        output out_right_opt, out_pc_jump, out_reg_wen, out_mem_wen,
        output out_load, out_wmask, out_word, out_illegal, out_ebreak
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
        input  out_func3, out_imm, out_alu_opt, out_left_opt,
        input  out_right_opt, out_pc_jump, out_reg_wen, out_mem_wen,
        input  out_load, out_wmask, out_word, out_illegal, out_ebreak
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational decode into a DEPTH-entry
// bundle queue, with flush and a sticky halt once an ebreak drains.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    decode_stage_if.slave  bus,
    output logic           halt
);
    localparam int  PW   = $clog2(DEPTH);
    localparam int  MW   = XLEN / 8;
    localparam bit  RV64 = (XLEN == 64);

    localparam logic [MW-1:0] M_B = MW'(8'h01);
    localparam logic [MW-1:0] M_H = MW'(8'h03);
    localparam logic [MW-1:0] M_W = MW'(8'h0F);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      func3;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_opt;
        logic [1:0]      left_opt;
        logic [1:0]      right_opt;
        logic [1:0]      pc_jump;
        logic            reg_wen;
        logic            mem_wen;
        logic            load;
        logic [MW-1:0]   wmask;
        logic            word;
        logic            illegal;
        logic            ebreak;
    } bundle_t;

    function automatic logic [3:0] alu_of(input logic [2:0] f3,
                                          input logic sub);
        logic [3:0] a;
        a = 4'd0;
        case (f3)
            3'b000:  a = sub ? 4'd1 : 4'd0;
            3'b001:  a = 4'd8;
            3'b010:  a = 4'd6;
            3'b011:  a = 4'd6;
            3'b100:  a = 4'd5;
            3'b101:  a = 4'd9;
            3'b110:  a = 4'd4;
            default: a = 4'd3;
        endcase
        return a;
    endfunction

    bundle_t         q [DEPTH];
    bundle_t         d;
    bundle_t         head;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [PW:0]     count;
    logic            blocked;
    logic            push;
    logic            pop;

    logic [31:0]        inst;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;
    logic op_r, op_rw, op_i, op_iw, op_br, op_jal, op_jalr;
    logic op_ld, op_st, op_lui, op_auipc, op_sys;

    assign inst = bus.in_inst;
    assign opc  = inst[6:0];
    assign f3   = inst[14:12];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};

    assign op_r     = (opc == 7'b0110011);
    assign op_rw    = (opc == 7'b0111011);
    assign op_i     = (opc == 7'b0010011);
    assign op_iw    = (opc == 7'b0011011);
    assign op_br    = (opc == 7'b1100011);
    assign op_jal   = (opc == 7'b1101111);
    assign op_jalr  = (opc == 7'b1100111);
    assign op_ld    = (opc == 7'b0000011);
    assign op_st    = (opc == 7'b0100011);
    assign op_lui   = (opc == 7'b0110111);
    assign op_auipc = (opc == 7'b0010111);
    assign op_sys   = (opc == 7'b1110011);

    // Decode the incoming word into a bundle by instruction class.
    always_comb begin
        d         = '0;
        d.pc      = bus.in_pc;
        d.rs1     = inst[19:15];
        d.rs2     = inst[24:20];
        d.rd      = inst[11:7];
        d.func3   = f3;
        d.pc_jump = 2'd3;
        unique case (1'b1)
            op_r, op_rw: begin
                d.right_opt = 2'd2;
                d.alu_opt   = alu_of(f3, inst[30]);
                d.reg_wen   = 1'b1;
                d.word      = op_rw;
                d.illegal   = op_rw && !RV64;
            end
            op_i, op_iw: begin
                d.imm     = XLEN'(imm_i);
                d.alu_opt = alu_of(f3, 1'b0);
                d.reg_wen = 1'b1;
                d.word    = op_iw;
                d.illegal = (op_iw && !RV64) ||
                            (!RV64 && f3[1:0] == 2'b01 && inst[25]);
            end
            op_br: begin
                d.imm       = XLEN'(imm_b);
                d.right_opt = 2'd2;
                d.alu_opt   = (f3[2:1] == 2'b00) ? 4'd7 : 4'd6;
                d.pc_jump   = 2'd2;
            end
            op_jal, op_jalr: begin
                d.imm       = op_jal ? XLEN'(imm_j) : XLEN'(imm_i);
                d.left_opt  = 2'd1;
                d.right_opt = 2'd1;
                d.pc_jump   = op_jal ? 2'd0 : 2'd1;
                d.reg_wen   = 1'b1;
            end
            op_ld: begin
                d.imm     = XLEN'(imm_i);
                d.load    = 1'b1;
                d.reg_wen = 1'b1;
                d.illegal = (f3 == 3'b111) ||
                            (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            op_st: begin
                d.imm     = XLEN'(imm_s);
                d.mem_wen = 1'b1;
                case (f3)
                    3'b000:  d.wmask = M_B;
                    3'b001:  d.wmask = M_H;
                    3'b010:  d.wmask = M_W;
                    3'b011:  begin
                        d.wmask   = '1;
                        d.illegal = !RV64;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            op_lui: begin
                d.imm       = XLEN'(imm_u);
                d.left_opt  = 2'd2;
                d.right_opt = 2'd3;
                d.reg_wen   = 1'b1;
            end
            op_auipc: begin
                d.imm      = XLEN'(imm_u);
                d.left_opt = 2'd1;
                d.reg_wen  = 1'b1;
            end
            op_sys: begin
                d.ebreak  = (inst == 32'h0010_0073);
                d.illegal = !d.ebreak;
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.reg_wen = 1'b0;
            d.mem_wen = 1'b0;
            d.load    = 1'b0;
            d.wmask   = '0;
            d.pc_jump = 2'd3;
        end
        if (d.rd == 5'd0)
            d.reg_wen = 1'b0;
    end

    assign bus.in_ready  = (count != DEPTH[PW:0]) && !blocked && !halt;
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    assign head = bus.out_valid ? q[rptr] : '0;

    // Store accepted bundles; contents need no reset since head is gated.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst)
            q[wptr] <= d;
    end

    // Queue pointers, occupancy, ebreak blocking and sticky halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            blocked <= 1'b0;
            halt    <= 1'b0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            blocked <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
                if (d.ebreak)
                    blocked <= 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
                if (head.ebreak)
                    halt <= 1'b1;
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign bus.out_pc        = head.pc;
    assign bus.out_rs1       = head.rs1;
    assign bus.out_rs2       = head.rs2;
    assign bus.out_rd        = head.rd;
    assign bus.out_func3     = head.func3;
    assign bus.out_imm       = head.imm;
    assign bus.out_alu_opt   = head.alu_opt;
    assign bus.out_left_opt  = head.left_opt;
    assign bus.out_right_opt = head.right_opt;
    assign bus.out_pc_jump   = head.pc_jump;
    assign bus.out_reg_wen   = head.reg_wen;
    assign bus.out_mem_wen   = head.mem_wen;
    assign bus.out_load      = head.load;
    assign bus.out_wmask     = head.wmask;
    assign bus.out_word      = head.word;
    assign bus.out_illegal   = head.illegal;
    assign bus.out_ebreak    = head.ebreak;
endmodule
